// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the data bus. It holds the grant until
// the slave completes, and a watchdog aborts accesses that hang.
module dbus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic        s_wen,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        grant_o
);

  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_BUSY = 1'b1;
  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic        WDOG_EN = (TIMEOUT_CYCLES != 0);

  logic [0:0]       r_state, w_state_nxt;
  logic             r_grant, w_grant_nxt;
  logic             r_last_grant, w_last_grant_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic        w_busy;
  logic        w_gvalid;
  logic        w_done;
  logic        w_tmo;
  logic        w_fin;
  logic [31:0] w_rdata;

  // Completion and watchdog qualifiers; a real s_ready beats a coincident timeout.
  always_comb begin
    w_busy   = (r_state == ST_BUSY);
    w_gvalid = r_grant ? m1_valid : m0_valid;
    w_done   = w_busy & w_gvalid & s_ready;
    w_tmo    = WDOG_EN & w_busy & w_gvalid & ~s_ready & (r_cnt == CNT_MAX);
    w_fin    = w_done | w_tmo;
    w_rdata  = w_done ? s_rdata : (w_tmo ? ERR_RDATA : 32'd0);
  end

  // Slave-side mux from the granted master, quiet while idle.
  always_comb begin
    s_valid = w_busy & w_gvalid;
    s_addr  = 32'd0;
    s_wen   = 1'b0;
    s_wdata = 32'd0;
    s_wstrb = 4'd0;
    if (w_busy) begin
      s_addr  = r_grant ? m1_addr  : m0_addr;
      s_wen   = r_grant ? m1_wen   : m0_wen;
      s_wdata = r_grant ? m1_wdata : m0_wdata;
      s_wstrb = r_grant ? m1_wstrb : m0_wstrb;
    end
  end

  // Master-side responses; the non-granted master sees all zeros.
  always_comb begin
    m0_ready = w_fin & ~r_grant;
    m0_err   = w_tmo & ~r_grant;
    m0_rdata = r_grant ? 32'd0 : w_rdata;
    m1_ready = w_fin & r_grant;
    m1_err   = w_tmo & r_grant;
    m1_rdata = r_grant ? w_rdata : 32'd0;
    grant_o  = r_grant;
  end

  // Next-state logic for arbitration, grant tracking and the watchdog counter.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (m0_valid || m1_valid) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = (m0_valid && m1_valid) ? ~r_last_grant : m1_valid;
        end
      end
      ST_BUSY: begin
        if (!w_gvalid) begin
          // Requester abandoned the access: drop it without touching fairness state.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_fin) begin
          w_state_nxt      = ST_IDLE;
          w_last_grant_nxt = r_grant;
          w_cnt_nxt        = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

endmodule
